// File: rtl/psychic5_objdma_ctrl_if.sv
// Sprite DMA bus bundle: Z80 bus handshake and read path on one side,
// attribute buffer write port on the other.
interface psychic5_objdma_ctrl_if;
  logic        o_BUSRQ_n;
  logic        i_BUSAK_n;
  logic [12:0] o_ADDR;
  logic        o_RD_n;
  logic        o_WR_n;
  logic [7:0]  i_DATA;
  logic [12:0] o_BUF_ADDR;
  logic [7:0]  o_BUF_DATA;
  logic        o_BUF_WE;

  modport master (
    output o_BUSRQ_n, o_ADDR, o_RD_n, o_WR_n, o_BUF_ADDR, o_BUF_DATA, o_BUF_WE,
    input  i_BUSAK_n, i_DATA
  );

  modport slave (
    input  o_BUSRQ_n, o_ADDR, o_RD_n, o_WR_n, o_BUF_ADDR, o_BUF_DATA, o_BUF_WE,
    output i_BUSAK_n, i_DATA
  );
endinterface

// File: rtl/psychic5_objdma_ctrl.sv
// Sprite DMA sequencer: once per frame trigger, borrow the Z80 bus and copy
// the sprite attribute table from main RAM into the attribute buffer.
module psychic5_objdma_ctrl #(
  parameter logic [12:0] SRC_BASE = 13'h1E00,
  parameter int unsigned XFER_LEN = 512,
  parameter int unsigned ACK_TMO  = 255
) (
  input  logic                          i_EMU_MCLK,
  input  logic                          i_EMU_MRST_n,
  input  logic                          i_EMU_CLK6MPCEN_n,
  input  logic                          i_FRAME_TRIG,
  input  logic                          i_HALT,
  psychic5_objdma_ctrl_if.master        bus,
  output logic                          o_BUSY,
  output logic                          o_DONE,
  output logic                          o_OVERRUN,
  output logic                          o_TMO
);

  localparam logic [12:0] LAST_IDX = 13'(XFER_LEN - 1);
  localparam logic [7:0]  TMO_LIM  = 8'(ACK_TMO);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_REL} state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  bdat_q, bdat_d;
  logic        trig_q;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        tmop_q, tmop_d;
  logic        trig_edge;

  assign trig_edge = i_FRAME_TRIG & ~trig_q;

  // State register, advances only on 6M enable edges
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      state_q <= S_IDLE;
    end else if (!i_EMU_CLK6MPCEN_n) begin
      state_q <= state_d;
    end
  end

  // Byte counter, ack timer, read latch, trigger history and status pulses
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      cnt_q  <= '0;
      tmo_q  <= '0;
      bdat_q <= '1;
      trig_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      tmop_q <= 1'b0;
    end else if (!i_EMU_CLK6MPCEN_n) begin
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
      bdat_q <= bdat_d;
      trig_q <= i_FRAME_TRIG;
      done_q <= done_d;
      ovr_q  <= ovr_d;
      tmop_q <= tmop_d;
    end
  end

  // Next-state and datapath update; losing BUSAK_n mid-copy aborts like a timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    bdat_d  = bdat_q;
    done_d  = 1'b0;
    tmop_d  = 1'b0;
    ovr_d   = trig_edge && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (trig_edge && !i_HALT) begin
          state_d = S_REQ;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      S_REQ: begin
        if (!bus.i_BUSAK_n) begin
          state_d = S_RD;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_LIM) begin
            state_d = S_REL;
            tmop_d  = 1'b1;
          end
        end
      end
      S_RD: begin
        if (bus.i_BUSAK_n) begin
          state_d = S_REL;
          tmop_d  = 1'b1;
        end else begin
          bdat_d  = bus.i_DATA;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (bus.i_BUSAK_n) begin
          state_d = S_REL;
          tmop_d  = 1'b1;
        end else if (cnt_q == LAST_IDX) begin
          state_d = S_REL;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 13'd1;
          state_d = S_RD;
        end
      end
      S_REL: begin
        if (bus.i_BUSAK_n) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decoded from state so an async reset releases the bus at once
  always_comb begin
    bus.o_BUSRQ_n = 1'b1;
    bus.o_RD_n    = 1'b1;
    bus.o_BUF_WE  = 1'b0;
    case (state_q)
      S_REQ: bus.o_BUSRQ_n = 1'b0;
      S_RD: begin
        bus.o_BUSRQ_n = 1'b0;
        bus.o_RD_n    = 1'b0;
      end
      S_WR: begin
        bus.o_BUSRQ_n = 1'b0;
        bus.o_RD_n    = 1'b0;
        bus.o_BUF_WE  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_ADDR     = SRC_BASE + cnt_q;
  assign bus.o_WR_n     = 1'b1;
  assign bus.o_BUF_ADDR = cnt_q;
  assign bus.o_BUF_DATA = bdat_q;
  assign o_BUSY         = (state_q != S_IDLE);
  assign o_DONE         = done_q;
  assign o_OVERRUN      = ovr_q;
  assign o_TMO          = tmop_q;

endmodule

// File: tb/tb_psychic5_objdma_ctrl.sv
// Bench for the sprite DMA sequencer: Z80 bus/RAM model, scoreboard of
// expected buffer writes and status events, directed plus random transfers.
`timescale 1ns/1ps
module tb_psychic5_objdma_ctrl;

  localparam logic [12:0] SRC = 13'h1E00;
  localparam int LEN = 4;
  localparam int TMO = 8;
  localparam int EN_NS = 40;

  localparam int EV_DONE = 1;
  localparam int EV_OVR  = 2;
  localparam int EV_TMO  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic halt = 1'b0;
  logic cen_n;
  logic busy, done, ovr, tmo;
  logic [1:0] phase = 2'd0;

  psychic5_objdma_ctrl_if bus ();

  psychic5_objdma_ctrl #(
    .SRC_BASE (SRC),
    .XFER_LEN (LEN),
    .ACK_TMO  (TMO)
  ) dut (
    .i_EMU_MCLK        (clk),
    .i_EMU_MRST_n      (rst_n),
    .i_EMU_CLK6MPCEN_n (cen_n),
    .i_FRAME_TRIG      (trig),
    .i_HALT            (halt),
    .bus               (bus.master),
    .o_BUSY            (busy),
    .o_DONE            (done),
    .o_OVERRUN         (ovr),
    .o_TMO             (tmo)
  );

  always #5 clk = ~clk;

  // One enable edge in every four MCLK edges
  always @(posedge clk) phase <= phase + 2'd1;
  assign cen_n = (phase != 2'd3);

  // Main RAM model answering DMA reads
  logic [7:0] mem [8192];
  assign bus.i_DATA = (!bus.o_RD_n) ? mem[bus.o_ADDR] : 8'h5A;

  int n_cmp = 0;
  int n_err = 0;
  logic [20:0] wq[$];
  int evq[$];
  time t_done = 0;
  time t_tmo = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic en_sample();
    do @(negedge clk); while (phase != 2'd3);
  endtask

  // Z80 model: grants the bus ack_dly enables after BUSRQ_n, releases rel_dly after drop
  int ack_dly = 0;
  int rel_dly = 0;
  int acnt = 0;
  int rcnt = 0;
  initial bus.i_BUSAK_n = 1'b1;
  always @(negedge clk) begin
    if (phase == 2'd3) begin
      if (!bus.o_BUSRQ_n) begin
        rcnt = 0;
        if (bus.i_BUSAK_n) begin
          if (acnt >= ack_dly) bus.i_BUSAK_n = 1'b0;
          else acnt++;
        end
      end else begin
        acnt = 0;
        if (!bus.i_BUSAK_n) begin
          if (rcnt >= rel_dly) bus.i_BUSAK_n = 1'b1;
          else rcnt++;
        end
      end
    end
  end

  task automatic ev_check(input int code, input string nm);
    if (evq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_%s: got pulse want none", nm);
    end else begin
      chk({"event_", nm}, 32'(code), 32'(evq.pop_front()));
    end
  endtask

  // Monitor: one look per enable period, pops the scoreboard on each output event
  always @(negedge clk) begin
    if (phase == 2'd3 && rst_n) begin
      if (bus.o_BUF_WE) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h want none",
                   bus.o_BUF_ADDR, bus.o_BUF_DATA);
        end else begin
          chk("buf_write", 32'({bus.o_BUF_ADDR, bus.o_BUF_DATA}), 32'(wq.pop_front()));
        end
        chk("rd_n_in_write", 32'(bus.o_RD_n), 32'd0);
        chk("wr_n_const", 32'(bus.o_WR_n), 32'd1);
      end
      if (ovr) ev_check(EV_OVR, "overrun");
      if (done) begin
        t_done = $time;
        ev_check(EV_DONE, "done");
      end
      if (tmo) begin
        t_tmo = $time;
        ev_check(EV_TMO, "tmo");
      end
    end
  end

  // One transfer: expectations come from the table contents and the ack delay alone
  task automatic do_xfer(input int dly, input bit ovr_en, input int ovr_k, input bit halt_mid);
    bit   timeout;
    time  t0;
    int   budget;
    bit   idle_seen;
    ack_dly = dly;
    rel_dly = int'($urandom_range(0, 2));
    timeout = (dly >= TMO);
    if (!timeout)
      for (int i = 0; i < LEN; i++) begin
        logic [12:0] a;
        a = SRC + 13'(i);
        wq.push_back({13'(i), mem[a]});
      end
    if (ovr_en) evq.push_back(EV_OVR);
    evq.push_back(timeout ? EV_TMO : EV_DONE);

    en_sample();
    trig = 1'b1;
    t0 = $time;
    en_sample();
    chk("busrq_latency", 32'(bus.o_BUSRQ_n), 32'd0);
    chk("busy_on_accept", 32'(busy), 32'd1);
    trig = 1'b0;

    budget = 2 * LEN + (timeout ? TMO : dly) + 20;
    for (int k = 1; k <= budget; k++) begin
      en_sample();
      if (ovr_en && k == ovr_k) trig = 1'b1;
      if (ovr_en && k == ovr_k + 1) trig = 1'b0;
      if (halt_mid && k == 2) halt = 1'b1;
      if (k > ovr_k + 2 && evq.size() == 0 && wq.size() == 0) break;
    end
    trig = 1'b0;
    chk("scoreboard_drained", 32'(wq.size() + evq.size()), 32'd0);
    if (timeout) chk("tmo_latency", 32'((t_tmo - t0) / EN_NS), 32'd9);
    else         chk("done_latency", 32'((t_done - t0) / EN_NS), 32'(dly + 2 + 2 * LEN));

    idle_seen = 1'b0;
    for (int k = 0; k < 20 && !idle_seen; k++) begin
      en_sample();
      if (!busy) idle_seen = 1'b1;
    end
    chk("idle_after_release", 32'(idle_seen), 32'd1);
    chk("busrq_released", 32'(bus.o_BUSRQ_n), 32'd1);
    halt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[13'h1E00] = 8'h11;
    mem[13'h1E01] = 8'h22;
    mem[13'h1E02] = 8'h33;
    mem[13'h1E03] = 8'h44;

    // Reset with random control inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      trig = 1'($urandom);
      halt = 1'($urandom);
    end
    chk("rst_busrq_n", 32'(bus.o_BUSRQ_n), 32'd1);
    chk("rst_rd_n", 32'(bus.o_RD_n), 32'd1);
    chk("rst_wr_n", 32'(bus.o_WR_n), 32'd1);
    chk("rst_addr", 32'(bus.o_ADDR), 32'(SRC));
    chk("rst_buf_addr", 32'(bus.o_BUF_ADDR), 32'd0);
    chk("rst_buf_data", 32'(bus.o_BUF_DATA), 32'hFF);
    chk("rst_buf_we", 32'(bus.o_BUF_WE), 32'd0);
    chk("rst_status", 32'({busy, done, ovr, tmo}), 32'd0);
    trig = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet bus with no trigger
    for (int i = 0; i < 100; i++) begin
      en_sample();
      chk("busrq_quiet", 32'(bus.o_BUSRQ_n), 32'd1);
    end

    // Basic 4-byte copy, ack three enables after request
    do_xfer(3, 1'b0, 0, 1'b0);

    // Halted trigger is ignored
    halt = 1'b1;
    en_sample();
    trig = 1'b1;
    for (int i = 0; i < 20; i++) begin
      en_sample();
      trig = 1'b0;
      chk("halt_busrq", 32'(bus.o_BUSRQ_n), 32'd1);
    end
    halt = 1'b0;

    // Trigger during a transfer
    do_xfer(3, 1'b1, 3, 1'b0);

    // No acknowledge ever
    do_xfer(255, 1'b0, 0, 1'b0);

    // Asynchronous reset while writing byte 2
    begin
      bit hit;
      ack_dly = 1;
      for (int i = 0; i < LEN; i++) begin
        logic [12:0] a;
        a = SRC + 13'(i);
        wq.push_back({13'(i), mem[a]});
      end
      evq.push_back(EV_DONE);
      en_sample();
      trig = 1'b1;
      en_sample();
      trig = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 30 && !hit; k++) begin
        en_sample();
        if (bus.o_BUF_WE && bus.o_BUF_ADDR == 13'd2) hit = 1'b1;
      end
      chk("reached_byte2", 32'(hit), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_busrq_n", 32'(bus.o_BUSRQ_n), 32'd1);
      chk("async_rd_n", 32'(bus.o_RD_n), 32'd1);
      chk("async_buf_we", 32'(bus.o_BUF_WE), 32'd0);
      wq.delete();
      evq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) en_sample();
      do_xfer(2, 1'b0, 0, 1'b0);
    end

    // Random transfers: fresh table, random ack delay, overrun and late halt
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < LEN; i++) begin
        logic [12:0] a;
        a = SRC + 13'(i);
        mem[a] = 8'($urandom);
      end
      do_xfer(int'($urandom_range(0, 9)), 1'($urandom), int'($urandom_range(2, 4)),
              1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
